button_seq_check: RTL
=====================

// Module: button_seq_check
// PURPOSE
//  Judges a player's controller presses against an expected sequence of 1..MAX_LEN button codes.
//  It is the multi-step successor of the single-press checker and sits between the
//  pattern generator (seq_data/seq_len) and the game-flow FSM (en/done/correct).
//  Adds press/release debouncing by edge, a per-step timeout, a hit counter and a strict/lenient mode.
// PARAMETERS
//  CODE_W       3           bits per button code; click width NUM_BTN = 2**CODE_W
//  MAX_LEN      8           max sequence length (steps)
//  LEN_W        4           width of seq_len/step_idx/hits, >= clog2(MAX_LEN+1)
//  TIMEOUT_CYC  50_000_000  per-step timeout in clk cycles; 0 disables timeout
//  TMR_W        26          timer width, must hold TIMEOUT_CYC
//  STOP_ON_MISS 1           1: first miss ends the run; 0: run all steps, count hits
// PORTS
//  clk        in   1                clock
//  rst        in   1                synchronous, active-high reset
//  en         in   1                level; 1 starts/holds a run, 0 aborts/re-arms
//  seq_len    in   LEN_W            steps in this run, sampled in IDLE when en=1
//  seq_data   in   MAX_LEN*CODE_W   step i code at [i*CODE_W +: CODE_W], sampled with seq_len
//  click      in   2**CODE_W        live one-hot button levels (0 = none pressed)
//  busy       out  1                1 in ARM/WAIT/RELEASE/RESULT
//  press_vld  out  1                1-cycle pulse when a press/timeout is judged
//  press_ok   out  1                valid with press_vld: 1 = step matched
//  step_idx   out  LEN_W            current step, 0-based
//  hits       out  LEN_W            matched steps so far
//  timed_out  out  1                sticky for the run: a step timed out
//  done       out  1                held 1 in DONE until en=0
//  correct    out  1                held with done: 1 = every step matched
// BEHAVIOUR
//  Reset (any state): state=IDLE; all outputs 0; timer, step, hits, latched seq cleared.
//  Match rule: step i hits iff click == (1 << code_i) exactly; multi-bit click = miss.
//  IDLE: done=correct=0. en=1 -> latch seq (len clamped to MAX_LEN), clear counters -> ARM.
//   seq_len=0: go straight to RESULT (correct=1, hits=0).
//  ARM (1 cycle): timer=0 -> WAIT. Judges nothing, even if click!=0 (stale press ignored via RELEASE
//   if click!=0: ARM -> RELEASE without judging or advancing the step).
//  WAIT: click==0 -> timer++. click!=0 -> judge: press_vld=1, press_ok=match, hits+=match -> RELEASE.
//   timer reaches TIMEOUT_CYC-1 with click==0 -> press_vld=1, press_ok=0, timed_out=1 -> miss path.
//   Miss with STOP_ON_MISS=1 -> RESULT directly (no release wait).
//  RELEASE: wait for click==0; then if step==len-1 -> RESULT else step++, timer=0 -> WAIT.
//   A press held across steps is never judged twice.
//  RESULT (1 cycle): correct <= (hits==len); done <= 1 -> DONE.
//  DONE: done=1, correct held, step_idx/hits frozen; en=0 -> IDLE (outputs cleared in IDLE).
//  Abort: en=0 in ARM/WAIT/RELEASE/RESULT -> IDLE next cycle; done never asserted; abort beats a
//   same-cycle press (no press_vld).
//  Latency: press edge -> press_vld on the next clk; last release -> done 2 clks later.
//  hits/step_idx never wrap: bounded by len <= MAX_LEN.
//  Sequence inputs are ignored outside IDLE.
// TESTING
//  len=3, codes {1,4,6}, press 0x02,rel,0x10,rel,0x40,rel -> 3 press_ok pulses, done=1, correct=1, hits=3.
//  STOP_ON_MISS=1, len=3, first press 0x04 (want 0x02) -> press_ok=0, done next+1, correct=0, hits=0.
//  STOP_ON_MISS=0, len=4, miss step1 only -> done=1, correct=0, hits=3, step_idx=3.
//  TIMEOUT_CYC=10, len=2, no press -> press_vld at cycle 10 of WAIT, timed_out=1, correct=0.
//  click 0x02 held through en rise, len=1 code 1 -> no judge until release+repress; then correct=1.
//  en drop mid-WAIT, and rst mid-RELEASE -> IDLE next clk, done=0, hits=0, no press_vld.

Source files
------------

// File: rtl/button_seq_check.sv
// Judges a player's button presses against a latched sequence of button codes.
// Presses are judged on their rising edge, and each one must be released before the next step.
module button_seq_check #(
  parameter int CODE_W       = 3,
  parameter int MAX_LEN      = 8,
  parameter int LEN_W        = 4,
  parameter int TIMEOUT_CYC  = 50_000_000,
  parameter int TMR_W        = 26,
  parameter int STOP_ON_MISS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [LEN_W-1:0]          seq_len,
  input  logic [MAX_LEN*CODE_W-1:0] seq_data,
  input  logic [2**CODE_W-1:0]      click,
  output logic                      busy,
  output logic                      press_vld,
  output logic                      press_ok,
  output logic [LEN_W-1:0]          step_idx,
  output logic [LEN_W-1:0]          hits,
  output logic                      timed_out,
  output logic                      done,
  output logic                      correct
);

  localparam int NUM_BTN = 2**CODE_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_RELEASE, S_RESULT, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [MAX_LEN*CODE_W-1:0] seq_q, seq_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          step_q, step_d;
  logic [LEN_W-1:0]          hits_q, hits_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic                      stale_q, stale_d;
  logic                      tout_q, tout_d;
  logic                      vld_q, vld_d;
  logic                      ok_q, ok_d;
  logic                      done_q, done_d;
  logic                      correct_q, correct_d;

  logic [CODE_W-1:0]         cur_code;
  logic                      match;
  logic                      timeout_hit;
  logic [LEN_W-1:0]          len_clamped;

  assign cur_code    = seq_q[step_q*CODE_W +: CODE_W];
  assign match       = (click == (NUM_BTN'(1) << cur_code));
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  assign len_clamped = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      seq_q     <= '0;
      len_q     <= '0;
      step_q    <= '0;
      hits_q    <= '0;
      timer_q   <= '0;
      stale_q   <= 1'b0;
      tout_q    <= 1'b0;
      vld_q     <= 1'b0;
      ok_q      <= 1'b0;
      done_q    <= 1'b0;
      correct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      len_q     <= len_d;
      step_q    <= step_d;
      hits_q    <= hits_d;
      timer_q   <= timer_d;
      stale_q   <= stale_d;
      tout_q    <= tout_d;
      vld_q     <= vld_d;
      ok_q      <= ok_d;
      done_q    <= done_d;
      correct_q <= correct_d;
    end
  end

  // A press already held when the run arms (stale) must be released without consuming a step.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    len_d     = len_q;
    step_d    = step_q;
    hits_d    = hits_q;
    timer_d   = timer_q;
    stale_d   = stale_q;
    tout_d    = tout_q;
    vld_d     = 1'b0;
    ok_d      = 1'b0;
    done_d    = done_q;
    correct_d = correct_q;

    case (state_q)
      S_IDLE: begin
        done_d    = 1'b0;
        correct_d = 1'b0;
        step_d    = '0;
        hits_d    = '0;
        tout_d    = 1'b0;
        stale_d   = 1'b0;
        timer_d   = '0;
        if (en) begin
          seq_d   = seq_data;
          len_d   = len_clamped;
          state_d = (len_clamped == '0) ? S_RESULT : S_ARM;
        end
      end
      S_ARM: begin
        timer_d = '0;
        if (click != '0) begin
          stale_d = 1'b1;
          state_d = S_RELEASE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (click != '0) begin
          vld_d   = 1'b1;
          ok_d    = match;
          hits_d  = hits_q + LEN_W'(match);
          state_d = (!match && STOP_ON_MISS != 0) ? S_RESULT : S_RELEASE;
        end else if (timeout_hit) begin
          vld_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = (STOP_ON_MISS != 0) ? S_RESULT : S_RELEASE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RELEASE: begin
        if (click == '0) begin
          timer_d = '0;
          if (stale_q) begin
            stale_d = 1'b0;
            state_d = S_WAIT;
          end else if (step_q == len_q - LEN_W'(1)) begin
            state_d = S_RESULT;
          end else begin
            step_d  = step_q + LEN_W'(1);
            state_d = S_WAIT;
          end
        end
      end
      S_RESULT: begin
        correct_d = (hits_q == len_q);
        done_d    = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping en wins over anything else judged this cycle.
    if (!en && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      step_d    = '0;
      hits_d    = '0;
      timer_d   = '0;
      stale_d   = 1'b0;
      tout_d    = 1'b0;
      vld_d     = 1'b0;
      ok_d      = 1'b0;
      done_d    = 1'b0;
      correct_d = 1'b0;
    end
  end

  assign busy      = (state_q == S_ARM) || (state_q == S_WAIT) ||
                     (state_q == S_RELEASE) || (state_q == S_RESULT);
  assign press_vld = vld_q;
  assign press_ok  = ok_q;
  assign step_idx  = step_q;
  assign hits      = hits_q;
  assign timed_out = tout_q;
  assign done      = done_q;
  assign correct   = correct_q;

endmodule
